ram_copy_engine: RTL
====================

// Module: ram_copy_engine
// PURPOSE
//   Initiator for the dual_port_ram block: copies a run of words within one RAM instance.
//   Port 0 reads the source range; port 1 writes the destination range.
//   One word per cycle is pipelined against the RAM's 1-cycle registered read latency.
//   Sits between a control FSM or CSR and the RAM; start/busy/done handshake.
// PARAMETERS
//   DATA_N  32                RAM word width (bits)
//   SIZE    128               RAM depth (words)
//   AW      $clog2(SIZE)      address width, derived; do not override
// PORTS
//   clk       in   1         clock, rising edge
//   rst_n     in   1         asynchronous active-low reset
//   start     in   1         request; sampled only in IDLE
//   src_addr  in   AW        first source word
//   dst_addr  in   AW        first destination word
//   len       in   AW+1      word count 0..SIZE; values >SIZE clamp to SIZE
//   busy      out  1         transfer in progress
//   done      out  1         1-cycle completion pulse
//   we0       out  1         RAM port 0 write enable; tied 0 (port 0 is read-only)
//   addr0     out  AW        RAM port 0 address (source)
//   w0_data   out  DATA_N    RAM port 0 write data; tied 0
//   r0_data   in   DATA_N    RAM port 0 read data; registered in RAM, 1-cycle latency
//   we1       out  1         RAM port 1 write enable
//   addr1     out  AW        RAM port 1 address (destination)
//   w1_data   out  DATA_N    RAM port 1 write data
//   r1_data   in   DATA_N    unused; ignored
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE. Counters and pointers are 0.
//   States and transitions:
//     IDLE -> RUN on start with len>0.
//     RUN -> DRAIN after the last read is issued.
//     DRAIN -> IDLE after the final write.
//   Start accepted at edge E0 with len=N>0. Cycle k is the cycle after edge E(k-1).
//     Cycle 1..N (RUN/issue): addr0 = src_addr+(k-1).
//     Cycle 2..N+1: we1=1, addr1=dst_addr+(k-2), w1_data=r0_data (combinational pass-through).
//     busy=1 in cycles 1..N+1. In cycle N+2: done=1, busy=0, state IDLE.
//   A start in the done cycle is accepted, so back-to-back transfers are allowed.
//   len=0: no RAM access; done=1 and busy=0 in cycle 1.
//   Pointers wrap modulo SIZE: AW-bit natural overflow; SIZE is a power of two.
//   start while busy is ignored. Inputs are captured at the accepting edge only.
//   Overlapping src/dst ranges: unsupported. Data result is unspecified; timing is unchanged.
//   we1=0 whenever busy=0. addr0 and addr1 are registered. addr0 holds its last value when idle.
//   Reset mid-transfer: immediate return to IDLE.
//     Words already written remain; no further writes; no done pulse.
// CONFIGURATION
//   RAM_COPY_FILL_EN defined:
//     Adds ports fill_mode (in, 1) and fill_value (in, DATA_N), both captured with start.
//     If fill_mode=1: port 0 stays idle and w1_data=fill_value.
//       we1=1 in cycles 1..N at dst_addr+(k-1); done in cycle N+1.
//   RAM_COPY_FILL_EN undefined:
//     Ports absent; copy-only behaviour as above.
// TESTING
//   T1 Reset: assert rst_n=0 mid-simulation -> busy, done, we1, addr0, addr1 all 0 asynchronously.
//   T2 Copy: ram[10..13]=A,B,C,D; src=10, dst=50, len=4.
//      -> we1 in cycles 2..5 at addr1 50..53 with A..D; done in cycle 6; ram[50..53]=A..D.
//   T3 Zero length: len=0 -> done in cycle 1; we1 never 1; busy never 1.
//   T4 Wrap (SIZE=128): src=126, dst=1, len=4.
//      -> addr0 sequence 126,127,0,1; ram[1..4] = old ram[126,127,0,1].
//   T5 Start while busy / reset mid-op: 2nd start in cycle 3 is ignored.
//      Then rst_n=0 in cycle 4 -> no we1 after reset; only dst words 0..1 written; no done.
//   T6 (RAM_COPY_FILL_EN) fill_mode=1, fill_value=32'hDEAD_BEEF, dst=20, len=3.
//      -> ram[20..22]=DEADBEEF; done in cycle 4; addr0 unchanged.

Source files
------------

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies a run of words inside one dual_port_ram; port 0 reads the source, port 1
// writes the destination. Define RAM_COPY_FILL_EN to add a constant-fill mode (fill_mode/fill_value).
module ram_copy_engine #(
  parameter int DATA_N = 32,
  parameter int SIZE   = 128,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     src_addr,
  input  logic [AW-1:0]     dst_addr,
  input  logic [AW:0]       len,
`ifdef RAM_COPY_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_N-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic              we0,
  output logic [AW-1:0]     addr0,
  output logic [DATA_N-1:0] w0_data,
  input  logic [DATA_N-1:0] r0_data,
  output logic              we1,
  output logic [AW-1:0]     addr1,
  output logic [DATA_N-1:0] w1_data,
  input  logic [DATA_N-1:0] r1_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FILL
  } state_e;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(SIZE);

  state_e              state_q, state_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [AW-1:0]       addr0_q, addr0_d;
  logic [AW-1:0]       addr1_q, addr1_d;
  logic                we1_q, we1_d;
  logic                done_q, done_d;
  logic                fill_q, fill_d;
  logic [DATA_N-1:0]   fill_val_q, fill_val_d;

  logic                fill_req;
  logic [DATA_N-1:0]   fill_req_val;
  logic [AW:0]         len_eff;
  logic                unused_r1;

`ifdef RAM_COPY_FILL_EN
  assign fill_req     = fill_mode;
  assign fill_req_val = fill_value;
`else
  assign fill_req     = 1'b0;
  assign fill_req_val = '0;
`endif

  // Port 1 is write-only from this block's point of view.
  assign unused_r1 = ^r1_data;

  assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      we1_q      <= 1'b0;
      done_q     <= 1'b0;
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      we1_q      <= we1_d;
      done_q     <= done_d;
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    we1_d      = 1'b0;
    done_d     = 1'b0;
    fill_d     = fill_q;
    fill_val_d = fill_val_q;

    // The write pointer advances after every cycle that carried a write.
    if (we1_q) addr1_d = addr1_q + AW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d      = len_eff;
            addr1_d    = dst_addr;
            fill_d     = fill_req;
            fill_val_d = fill_req_val;
            if (fill_req) begin
              we1_d   = 1'b1;
              state_d = S_FILL;
            end else begin
              addr0_d = src_addr;
              state_d = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        // Data read this cycle lands next cycle, so the matching write trails by one.
        we1_d = 1'b1;
        cnt_d = cnt_q - (AW+1)'(1);
        if (cnt_q == (AW+1)'(1)) state_d = S_DRAIN;
        else                     addr0_d = addr0_q + AW'(1);
      end
      S_DRAIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FILL: begin
        cnt_d = cnt_q - (AW+1)'(1);
        if (cnt_q == (AW+1)'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          we1_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign we0     = 1'b0;
  assign w0_data = '0;
  assign addr0   = addr0_q;
  assign we1     = we1_q;
  assign addr1   = addr1_q;
  assign w1_data = we1_q ? (fill_q ? fill_val_q : r0_data) : '0;

endmodule
